spi: RTL and testbench

- Single-channel SPI master that reads one conversion from an 8-channel, 12-bit serial ADC (ADC128S022-style, 16-clock frame).
- On a `start` pulse it lowers `CS_N` and runs 16 `SCLK` cycles.
- During the frame it shifts the 3-bit channel address out on `DIN` and captures 12 result bits from `DOUT`.
- It then raises `CS_N`, presents `data` and pulses `done`. It sits between system control logic and the off-chip ADC pins.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_if.sv | 23 ++
 rtl/spi_sclk_gen.sv | 41 ++++
 rtl/spi.sv | 105 ++++++++++
 tb/tb_spi.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the ADC128S022-style SPI master.
package spi_pkg;
  localparam int FRAME_BITS       = 16;
  localparam int RESULT_BITS      = 12;
  localparam int ADDR_FIRST_CYCLE = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    FINISH
  } state_e;
endpackage

// File: rtl/spi_if.sv
// Request/result handshake between system control logic and the SPI master.
interface spi_if;
  import spi_pkg::*;

  logic                   start;
  logic [2:0]             channel;
  logic                   done;
  logic [RESULT_BITS-1:0] data;

  modport master (
    output start,
    output channel,
    input  done,
    input  data
  );

  modport slave (
    input  start,
    input  channel,
    output done,
    output data
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: edge/sample strobes and SCLK cycle counter.
module spi_sclk_gen #(
  parameter int SCLK_HALF = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       fall,
  output logic       rise,
  output logic       sample,
  output logic [4:0] cyc
);
  localparam int CW = $clog2(2 * SCLK_HALF);
  localparam logic [CW-1:0] C_HALF = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(2 * SCLK_HALF - 1);
  localparam logic [CW-1:0] C_SAMP = CW'(SCLK_HALF - 1 + SCLK_HALF / 2);

  logic [CW-1:0] cnt;
  logic          first;

  // cycle 0 is the CS setup period: only a high half before the first fall
  assign first  = (cyc == 5'd0);
  assign fall   = en && (cnt == (first ? C_HALF : C_LAST));
  assign rise   = en && !first && (cnt == C_HALF);
  assign sample = en && !first && (cnt == C_SAMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      cyc <= '0;
    end else if (!en) begin
      cnt <= '0;
      cyc <= '0;
    end else if (fall) begin
      cnt <= '0;
      cyc <= cyc + 5'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi.sv
// SPI master reading one 12-bit conversion per 16-clock ADC frame.
module spi
  import spi_pkg::*;
#(
  parameter int SCLK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  spi_if.slave bus,
  output logic SCLK,
  output logic CS_N,
  output logic DIN,
  input  logic DOUT
);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_FINISH = FINISH;

  logic [1:0]             state;
  logic [2:0]             ch;
  logic [RESULT_BITS-1:0] shift;
  logic                   en;
  logic                   fall;
  logic                   rise;
  logic                   sample;
  logic [4:0]             cyc;
  logic [4:0]             n;
  logic [4:0]             off;
  logic                   last;
  logic                   din_nx;

  assign en   = (state == S_SETUP) || (state == S_SHIFT);
  assign n    = cyc + 5'd1;
  assign off  = n - 5'(ADDR_FIRST_CYCLE);
  assign last = (cyc == 5'(FRAME_BITS));

  spi_sclk_gen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .fall  (fall),
    .rise  (rise),
    .sample(sample),
    .cyc   (cyc)
  );

  // address bits go out MSB first in the cycle that is about to start
  always_comb begin
    din_nx = 1'b0;
    unique case (off)
      5'd0:    din_nx = ch[2];
      5'd1:    din_nx = ch[1];
      5'd2:    din_nx = ch[0];
      default: din_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch       <= '0;
      shift    <= '0;
      SCLK     <= 1'b1;
      CS_N     <= 1'b1;
      DIN      <= 1'b0;
      bus.done <= 1'b0;
      bus.data <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            ch    <= bus.channel;
            CS_N  <= 1'b0;
            state <= S_SETUP;
          end
        end
        S_SETUP, S_SHIFT: begin
          if (rise) SCLK <= 1'b1;
          if (sample) shift <= {shift[RESULT_BITS-2:0], DOUT};
          if (fall) begin
            if (last) begin
              CS_N  <= 1'b1;
              DIN   <= 1'b0;
              state <= S_FINISH;
            end else begin
              SCLK  <= 1'b0;
              DIN   <= din_nx;
              state <= S_SHIFT;
            end
          end
        end
        S_FINISH: begin
          bus.done <= 1'b1;
          bus.data <= shift;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi.sv
// Directed bench for spi: ADC pin model, frame timing and data checks.
module tb_spi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SCLK, CS_N, DIN;
  logic DOUT = 1'b0;

  spi_if bus ();

  spi #(.SCLK_HALF(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .SCLK (SCLK),
    .CS_N (CS_N),
    .DIN  (DIN),
    .DOUT (DOUT)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // ADC model and frame monitor
  logic [15:0] adc_word = '0;
  logic [15:0] din_vec = '0;
  int cs_low = 0, rises = 0, done_cnt = 0, done_total = 0;
  int minp = 0, maxp = 0, clk_i = 0, last_rise = 0;
  logic sclk_q = 1'b1, cs_q = 1'b1;

  always @(negedge clk) begin
    clk_i++;
    if (!CS_N && cs_q) begin
      cs_low = 0; rises = 0; din_vec = '0;
      done_cnt = 0; minp = 9999; maxp = 0;
    end
    if (!CS_N) cs_low++;
    if (!CS_N && SCLK && !sclk_q) begin
      if (rises > 0) begin
        if (clk_i - last_rise < minp) minp = clk_i - last_rise;
        if (clk_i - last_rise > maxp) maxp = clk_i - last_rise;
      end
      last_rise = clk_i;
      rises++;
      if (rises <= 16) begin
        din_vec[16-rises] = DIN;
        DOUT = adc_word[16-rises];
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_total++;
    end
    sclk_q = SCLK;
    cs_q = CS_N;
  end

  task automatic frame(input logic [2:0] ch, input logic [15:0] word,
                       input bit full);
    bit seen;
    adc_word = word;
    bus.channel = ch;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("data", 32'(bus.data), 32'(word[11:0]));
    if (full) begin
      chk("cs_low_clks", cs_low, 264);
      chk("sclk_rises", rises, 16);
      chk("sclk_min_period", minp, 16);
      chk("sclk_max_period", maxp, 16);
      chk("din_bits", 32'(din_vec), 32'({2'b00, ch, 11'b0}));
      repeat (5) @(negedge clk);
      #1;
      chk("done_width", done_cnt, 1);
      chk("data_held", 32'(bus.data), 32'(word[11:0]));
    end
  endtask

  initial begin
    int dt;
    bit hit;
    real ph;
    logic [11:0] s;
    bus.start = 1'b0;
    bus.channel = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_data", 32'(bus.data), 32'h000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    frame(3'd3, 16'h0ABC, 1'b1);
    frame(3'd7, 16'hF123, 1'b1);

    // restart attempt and channel change while a frame is running
    fork
      frame(3'd5, 16'h0555, 1'b1);
      begin
        repeat (10) @(negedge clk);
        #1;
        bus.channel = 3'd2;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (90) @(negedge clk);
        #1;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
      end
    join

    // reset in the middle of SCLK cycle 8
    adc_word = 16'hFFFF;
    bus.channel = 3'd7;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk); #1;
      if (rises >= 8) hit = 1'b1;
    end
    chk("abort_reached_c8", 32'(hit), 32'd1);
    dt = done_total;
    rst_n = 1'b0;
    #1;
    chk("abort_sclk", 32'(SCLK), 32'd1);
    chk("abort_cs_n", 32'(CS_N), 32'd1);
    chk("abort_din", 32'(DIN), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_data", 32'(bus.data), 32'h000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    chk("abort_no_done", done_total, dt);

    // sine samples, mostly 200 ns apart, every fourth back-to-back
    for (int i = 0; i < 200; i++) begin
      ph = 2.0 * 3.14159265358979 * real'(i) / 200.0;
      s = 12'(int'(2048.0 + 2047.0 * $sin(ph)));
      frame(3'(i), {4'(i), s}, 1'b0);
      if (i % 4 != 0) begin
        repeat (10) @(negedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
